// File: rtl/uart_tx_fifo.sv
// Purpose : byte FIFO between a producer and the UART transmitter, first-word-fall-through.
// Latency : a byte pushed at edge N is visible on out_data/out_valid after edge N (no pass-through).
// Backpr. : in_ready = !full (a pop never frees a slot in the same cycle); out held while !out_ready.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   flush                 synchronous clear of contents and the overflow flag
//   in_valid/in_data      producer byte, accepted when in_ready
//   in_ready              FIFO can accept a byte
//   out_valid/out_data    head byte towards the transmitter, consumed when out_ready
//   count                 occupancy 0..DEPTH
//   empty/full            occupancy flags
//   almost_full           count >= AFULL_LEVEL
//   overflow              sticky: a write was attempted while full
module uart_tx_fifo #(
   parameter int DEPTH_LOG2  = 4,
   parameter int AFULL_LEVEL = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [7:0]            out_data,
   input  logic                  out_ready,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_full,
   output logic                  overflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];
   localparam logic [DEPTH_LOG2:0] AFULL_CNT = AFULL_LEVEL[DEPTH_LOG2:0];

   logic [7:0]             mem [DEPTH];
   logic [DEPTH_LOG2-1:0]  wr_ptr;
   logic [DEPTH_LOG2-1:0]  rd_ptr;
   logic [DEPTH_LOG2:0]    count_q;
   logic                   overflow_q;
   logic                   push;
   logic                   pop;

   // All flags derive from the registered count so nothing combinational
   // runs from in_valid/out_ready through to the handshake outputs.
   assign empty       = (count_q == '0);
   assign full        = (count_q == DEPTH_CNT);
   assign almost_full = (count_q >= AFULL_CNT);
   assign in_ready    = !full;
   assign out_valid   = !empty;
   assign out_data    = mem[rd_ptr];
   assign count       = count_q;
   assign overflow    = overflow_q;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   // Storage has no reset; stale entries are unreachable once the pointers
   // are cleared. Writes are suppressed on reset/flush so the discarded byte
   // never lands in the array.
   always_ff @(posedge clk) begin
      if (push && !reset && !flush) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         // Pointers wrap modulo DEPTH by width; count carries the extra bit
         // that separates full from empty.
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         // The write is dropped (push is low while full); only the flag records it.
         if (in_valid && full) begin
            overflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (count_q <= DEPTH_CNT);
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Purpose : self-checking bench for uart_tx_fifo against a queue-based reference model.
// Latency : model updated at each rising edge, DUT outputs compared 1 time unit later.
// Backpr. : stimulus drives in_valid/out_ready freely; the model decides what is accepted.
module tb_uart_tx_fifo;

   localparam int DL    = 4;
   localparam int DEPTH = 16;
   localparam int AFL   = 12;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          out_valid;
   logic [7:0]    out_data;
   logic          out_ready;
   logic [DL:0]   count;
   logic          empty;
   logic          full;
   logic          almost_full;
   logic          overflow;

   uart_tx_fifo #(.DEPTH_LOG2(DL), .AFULL_LEVEL(AFL)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .count       (count),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   // Reference model: contents as a plain queue plus the sticky flag.
   byte unsigned q[$];
   bit           ovf_m;
   int           n_vec;
   int           n_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      int  n;
      bit  acc;
      bit  take;
      n = q.size();
      if (reset || flush) begin
         q.delete();
         ovf_m = 1'b0;
      end else begin
         acc  = in_valid && (n < DEPTH);
         take = out_ready && (n > 0);
         if (in_valid && n == DEPTH) ovf_m = 1'b1;
         if (take) void'(q.pop_front());
         if (acc)  q.push_back(in_data);
      end
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("count",       32'(count),       32'(n));
      chk("empty",       32'(empty),       32'(n == 0));
      chk("full",        32'(full),        32'(n == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(n >= AFL));
      chk("in_ready",    32'(in_ready),    32'(n < DEPTH));
      chk("out_valid",   32'(out_valid),   32'(n > 0));
      chk("overflow",    32'(overflow),    32'(ovf_m));
      if (n > 0) chk("out_data", 32'(out_data), 32'(q[0]));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      ovf_m = 1'b0;
      idle_inputs();

      // Reset then idle.
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_count",    32'(count),     32'd0);
      chk("rst_empty",    32'(empty),     32'd1);
      chk("rst_in_ready", 32'(in_ready),  32'd1);
      chk("rst_out_vld",  32'(out_valid), 32'd0);
      chk("rst_overflow", 32'(overflow),  32'd0);
      step();

      // Single byte held while the transmitter is busy.
      in_valid = 1'b1;
      in_data  = 8'h55;
      step();
      in_valid = 1'b0;
      chk("single_data",  32'(out_data), 32'h55);
      chk("single_count", 32'(count),    32'd1);
      repeat (10) step();
      chk("single_hold",  32'(out_data), 32'h55);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("single_empty", 32'(empty), 32'd1);

      // Fill to full, overflow attempt, drain in order.
      for (int i = 0; i < DEPTH; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i);
         step();
         chk("fill_afull", 32'(almost_full), 32'(i + 1 >= AFL));
      end
      chk("fill_full", 32'(full), 32'd1);
      in_data = 8'hAA;
      step();
      in_valid = 1'b0;
      chk("ovf_set",   32'(overflow), 32'd1);
      chk("ovf_count", 32'(count),    32'd16);
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain_order", 32'(out_data), 32'(i));
         step();
      end
      out_ready = 1'b0;
      chk("drain_empty", 32'(empty), 32'd1);

      // Simultaneous push/pop at count 5, long enough to wrap twice.
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         step();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         in_data = 8'($urandom);
         step();
         chk("pp_count", 32'(count), 32'd5);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;

      // Flush mid-operation with overflow set and a coincident push.
      in_valid = 1'b1;
      while (q.size() < DEPTH) begin
         in_data = 8'($urandom);
         step();
      end
      step();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (9) step();
      out_ready = 1'b0;
      chk("pre_flush_count", 32'(count),    32'd7);
      chk("pre_flush_ovf",   32'(overflow), 32'd1);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h33;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_count", 32'(count),     32'd0);
      chk("flush_vld",   32'(out_valid), 32'd0);
      chk("flush_ovf",   32'(overflow),  32'd0);
      out_ready = 1'b1;
      repeat (3) step();
      out_ready = 1'b0;

      // Randomized traffic with varying push/pop bias plus rare flush/reset.
      for (int ph = 0; ph < 8; ph++) begin
         int pin;
         int pout;
         pin  = $urandom_range(10, 90);
         pout = $urandom_range(10, 90);
         for (int c = 0; c < 500; c++) begin
            in_valid  = ($urandom_range(0, 99) < pin);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 99) < pout);
            flush     = ($urandom_range(0, 199) == 0);
            reset     = ($urandom_range(0, 499) == 0);
            step();
         end
      end
      idle_inputs();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO that sits directly upstream of the UART transmitter.
- Absorbs bursts from the producer (CPU bus, protocol engine) and presents bytes to the transmitter one at a time over a valid/ready handshake.
- Has first-word-fall-through output, occupancy reporting, almost-full flag, synchronous flush and a sticky overflow flag for dropped writes.

Parameters:
- DEPTH_LOG2, 4, log2 of storage depth; DEPTH = 2**DEPTH_LOG2 entries (legal 1..8).
- AFULL_LEVEL, 12, almost_full asserts when count >= AFULL_LEVEL (legal 1..DEPTH).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of contents and overflow flag.
- in_valid  input  1  producer has a byte.
- in_data  input  8  byte to enqueue.
- in_ready  output  1  FIFO can accept a byte (= !full).
- out_valid  output  1  head byte available; drives transmitter valid.
- out_data  output  8  head byte; drives transmitter in.
- out_ready  input  1  transmitter ready.
- count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- almost_full  output  1  count >= AFULL_LEVEL.
- overflow  output  1  sticky; a write was attempted while full.

Behaviour:
- Storage: DEPTH x 8 array, wr_ptr and rd_ptr of DEPTH_LOG2 bits, wrap naturally modulo DEPTH, plus count register.
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- Reset (sync, high): wr_ptr = rd_ptr = 0, count = 0, overflow = 0.
  - Resulting outputs: in_ready = 1, out_valid = 0, empty = 1, full = 0, almost_full = 0.
  - out_data is don't-care while out_valid = 0.
  - Array contents are not cleared.
  - Reset mid-burst discards all queued bytes; any pending pop that cycle is ignored.
- flush: same effect as reset on pointers, count and overflow. Reset has priority over flush; flush has priority over push/pop in the same cycle, so the pushed byte is discarded.
- Flags:
  - empty, full, almost_full and in_ready are combinational from registered count.
  - out_valid = !empty.
  - out_data = mem[rd_ptr] (combinational read).
- Latency: push into empty FIFO at edge N gives out_valid = 1 and out_data = that byte after edge N; no same-cycle pass-through.
- Hold: while out_valid && !out_ready, out_data and out_valid stay stable until popped, even if pushes occur.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, and both pointers advance.
- Full: in_ready = 0, so a pop in that cycle does not admit a push; in_ready rises the cycle after the pop.
- Overflow: in_valid && full (write attempted while full) sets overflow = 1 on the next edge; data is dropped and count is unchanged. overflow holds until reset or flush.
- Empty: out_valid = 0; out_ready is ignored; count never underflows.
- Ordering: strict FIFO, including across pointer wrap from DEPTH-1 to 0.

Test Plan:
- Reset then idle: after reset = 1 for 1 cycle -> count = 0, empty = 1, in_ready = 1, out_valid = 0, overflow = 0.
- Single byte, transmitter busy: push 0x55 with out_ready = 0 -> next cycle out_valid = 1, out_data = 0x55, count = 1. Hold out_ready = 0 for 10 cycles -> data stable. Raise out_ready for 1 cycle -> empty = 1.
- Fill to full with defaults (DEPTH = 16): push 0x00..0x0F with out_ready = 0 -> almost_full = 1 once count = 12, full = 1 and in_ready = 0 at count = 16. Extra push of 0xAA -> overflow = 1, count stays 16. Drain with out_ready = 1 -> bytes emerge 0x00..0x0F in order; 0xAA never appears.
- Simultaneous push/pop at count = 5: one cycle with both handshakes -> count stays 5, order preserved. Repeat for 40 cycles so pointers wrap twice -> output sequence equals input sequence.
- Flush mid-operation: count = 7, overflow = 1, assert flush together with a push of 0x33 -> next cycle count = 0, out_valid = 0, overflow = 0, and 0x33 never emerges.
- Loopback with transmitter: FIFO feeds the transmitter (24 MHz clock, 115200 baud) and its line is looped to the receiver. Push "HELLO" (0x48 0x45 0x4C 0x4C 0x4F) in 5 consecutive cycles -> receiver reports the same 5 bytes in order with error = 0 and overrun = 0.
